spi_master_ctrl: RTL and testbench

SPI_MASTER_CTRL -- requirements
Module: spi_master_ctrl

---
 rtl/shared_pkg.sv | 28 ++
 rtl/spi_master_ctrl_if.sv | 29 ++
 rtl/spi_mst_shifter.sv | 66 ++++++
 rtl/spi_master_ctrl.sv | 152 +++++++++++++++
 tb/tb_spi_master_ctrl.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/shared_pkg.sv
// Constants shared between the SPI RAM slave and the SPI master controller:
// frame command codes, frame geometry and the master FSM state encoding.
package shared_pkg;

  localparam int SLV_CMD_W   = 2;
  localparam int SLV_DATA_W  = 8;
  localparam int SLV_FRAME_W = SLV_CMD_W + SLV_DATA_W;

  // Two-bit command prefix carried in front of every 10-bit frame.
  typedef enum logic [1:0] {
    CMD_WR_ADDR = 2'b00,
    CMD_WR_DATA = 2'b01,
    CMD_RD_ADDR = 2'b10,
    CMD_RD_DATA = 2'b11
  } frame_cmd_e;

  typedef enum logic [2:0] {
    MST_IDLE      = 3'd0,
    MST_START     = 3'd1,
    MST_SHIFT     = 3'd2,
    MST_WAIT_MISO = 3'd3,
    MST_CAPTURE   = 3'd4,
    MST_END       = 3'd5
  } mst_state_e;

  localparam int MST_CAPTURE_CYCLES = 8;

endpackage

// File: rtl/spi_master_ctrl_if.sv
// Host request/response handshake plus the SPI pins of the master controller.
// The controller uses the slave modport, the host/slave-model side uses master.
interface spi_master_ctrl_if #(
  parameter int ADDR_SIZE = 8
) ();

  logic                 req_valid;
  logic                 req_ready;
  logic                 req_wr;
  logic [ADDR_SIZE-1:0] req_addr;
  logic [7:0]           req_wdata;
  logic                 rsp_valid;
  logic [7:0]           rsp_rdata;
  logic                 SS_n;
  logic                 MOSI;
  logic                 MISO;
  logic                 busy;

  modport slave (
    input  req_valid, req_wr, req_addr, req_wdata, MISO,
    output req_ready, rsp_valid, rsp_rdata, SS_n, MOSI, busy
  );

  modport master (
    output req_valid, req_wr, req_addr, req_wdata, MISO,
    input  req_ready, rsp_valid, rsp_rdata, SS_n, MOSI, busy
  );

endinterface

// File: rtl/spi_mst_shifter.sv
// Datapath of the SPI master: frame serializer (MSB first), read-data
// deserializer and the per-state cycle counter used by the controller FSM.
module spi_mst_shifter
  import shared_pkg::*;
#(
  parameter int FRAME_W = 10,
  parameter int CNT_W   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_i,
  input  logic                  shift_i,
  input  logic                  cnt_clr_i,
  input  logic                  capture_i,
  input  logic                  miso_i,
  input  logic [FRAME_W-1:0]    frame_i,
  output logic                  mosi_o,
  output logic [CNT_W-1:0]      cnt_o,
  output logic [SLV_DATA_W-1:0] rx_byte_o
);

  // The MSB goes straight to mosi_q on load, so only FRAME_W-1 bits are kept.
  logic [FRAME_W-2:0]    piso_q;
  logic                  mosi_q;
  logic [SLV_DATA_W-2:0] sipo_q;
  logic [CNT_W-1:0]      cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      piso_q <= '0;
      mosi_q <= 1'b0;
    end else if (load_i) begin
      mosi_q <= frame_i[FRAME_W-1];
      piso_q <= frame_i[FRAME_W-2:0];
    end else if (shift_i) begin
      mosi_q <= piso_q[FRAME_W-2];
      piso_q <= {piso_q[FRAME_W-3:0], 1'b0};
    end else begin
      mosi_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sipo_q <= '0;
    end else if (capture_i) begin
      sipo_q <= {sipo_q[SLV_DATA_W-3:0], miso_i};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (cnt_clr_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign mosi_o    = mosi_q;
  assign cnt_o     = cnt_q;
  // The eighth bit is taken live so the full byte is ready on the last capture edge.
  assign rx_byte_o = {sipo_q, miso_i};

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI master controller: turns host read/write requests into two SPI frames
// (address frame, then data frame) and returns read data on rsp_valid.
module spi_master_ctrl
  import shared_pkg::*;
#(
  parameter int ADDR_SIZE = 8,
  parameter int RD_GAP    = 2
) (
  input  logic              clk,
  input  logic              rst,
  spi_master_ctrl_if.slave  bus
);

  localparam int FRAME_W   = SLV_CMD_W + ADDR_SIZE;
  localparam int CNT_MAX_A = (FRAME_W > RD_GAP) ? FRAME_W : RD_GAP;
  localparam int CNT_MAX   = (CNT_MAX_A > MST_CAPTURE_CYCLES) ? CNT_MAX_A : MST_CAPTURE_CYCLES;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(FRAME_W - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'((RD_GAP > 0) ? RD_GAP - 1 : 0);
  localparam logic [CNT_W-1:0] CAP_LAST   = CNT_W'(MST_CAPTURE_CYCLES - 1);

  mst_state_e           state_q, state_d;
  logic                 first_q;
  logic                 wr_q;
  logic [ADDR_SIZE-1:0] addr_q;
  logic [7:0]           wdata_q;
  logic                 rdy_q;
  logic                 busy_q;
  logic                 ss_n_q;
  logic                 rsp_valid_q;
  logic [7:0]           rsp_rdata_q;

  logic                 accept_s;
  logic                 rd_data_frame_s;
  logic                 capture_done_s;
  logic [FRAME_W-1:0]   frame_s;
  logic [CNT_W-1:0]     cnt_s;
  logic                 mosi_s;
  logic [7:0]           rx_byte_s;

  assign accept_s        = bus.req_valid & rdy_q;
  assign rd_data_frame_s = ~wr_q & ~first_q;
  assign capture_done_s  = (state_q == MST_CAPTURE) && (state_d == MST_END);

  always_comb begin
    frame_s = '0;
    if (first_q) begin
      frame_s = {(wr_q ? CMD_WR_ADDR : CMD_RD_ADDR), addr_q};
    end else if (wr_q) begin
      frame_s = {CMD_WR_DATA, ADDR_SIZE'(wdata_q)};
    end else begin
      frame_s = {CMD_RD_DATA, {ADDR_SIZE{1'b0}}};
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      MST_IDLE: begin
        if (accept_s) state_d = MST_START;
        else          state_d = MST_IDLE;
      end
      MST_START: state_d = MST_SHIFT;
      MST_SHIFT: begin
        if (cnt_s == SHIFT_LAST) begin
          if (rd_data_frame_s) state_d = (RD_GAP > 0) ? MST_WAIT_MISO : MST_CAPTURE;
          else                 state_d = MST_END;
        end else begin
          state_d = MST_SHIFT;
        end
      end
      MST_WAIT_MISO: begin
        if (cnt_s == GAP_LAST) state_d = MST_CAPTURE;
        else                   state_d = MST_WAIT_MISO;
      end
      MST_CAPTURE: begin
        if (cnt_s == CAP_LAST) state_d = MST_END;
        else                   state_d = MST_CAPTURE;
      end
      MST_END: begin
        if (first_q) state_d = MST_START;
        else         state_d = MST_IDLE;
      end
      default: state_d = MST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= MST_IDLE;
    else     state_q <= state_d;
  end

  // Request fields are frozen at accept; first_q marks the address frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      first_q <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 8'h00;
    end else if (accept_s) begin
      first_q <= 1'b1;
      wr_q    <= bus.req_wr;
      addr_q  <= bus.req_addr;
      wdata_q <= bus.req_wdata;
    end else if (state_q == MST_END) begin
      first_q <= 1'b0;
    end
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdy_q       <= 1'b0;
      busy_q      <= 1'b0;
      ss_n_q      <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 8'h00;
    end else begin
      rdy_q       <= (state_d == MST_IDLE);
      busy_q      <= (state_d != MST_IDLE);
      ss_n_q      <= (state_d == MST_IDLE) || (state_d == MST_END);
      rsp_valid_q <= capture_done_s;
      if (capture_done_s) rsp_rdata_q <= rx_byte_s;
    end
  end

  spi_mst_shifter #(
    .FRAME_W (FRAME_W),
    .CNT_W   (CNT_W)
  ) u_shifter (
    .clk       (clk),
    .rst       (rst),
    .load_i    ((state_q == MST_START) && (state_d == MST_SHIFT)),
    .shift_i   ((state_q == MST_SHIFT) && (state_d == MST_SHIFT)),
    .cnt_clr_i (state_d != state_q),
    .capture_i (state_q == MST_CAPTURE),
    .miso_i    (bus.MISO),
    .frame_i   (frame_s),
    .mosi_o    (mosi_s),
    .cnt_o     (cnt_s),
    .rx_byte_o (rx_byte_s)
  );

  assign bus.req_ready = rdy_q;
  assign bus.busy      = busy_q;
  assign bus.SS_n      = ss_n_q;
  assign bus.MOSI      = mosi_s;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Bench for spi_master_ctrl: directed and random transactions compared cycle by
// cycle against an expected waveform built from the frame layout rules.
module tb_spi_master_ctrl;

  localparam int ADDR_SIZE = 8;
  localparam int RD_GAP    = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spi_master_ctrl_if #(.ADDR_SIZE(ADDR_SIZE)) bus ();

  spi_master_ctrl #(
    .ADDR_SIZE (ADDR_SIZE),
    .RD_GAP    (RD_GAP)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic ss;
    logic mosi;
    logic busy;
    logic rdy;
    logic vld;
  } cyc_t;

  cyc_t       exp_q[$];
  int         cap_first;
  logic [7:0] exp_rdata;
  int         n_checks = 0;
  int         n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Per-cycle picture of a transaction: idle/accept, two frames, idle again.
  task automatic build_expect(input bit wr, input logic [7:0] addr, input logic [7:0] wdata);
    logic [9:0] frames [2];
    frames[0] = {(wr ? 2'b00 : 2'b10), addr};
    frames[1] = wr ? {2'b01, wdata} : {2'b11, 8'h00};
    exp_q.delete();
    cap_first = -1;
    exp_q.push_back('{ss: 1'b1, mosi: 1'b0, busy: 1'b0, rdy: 1'b1, vld: 1'b0});
    for (int f = 0; f < 2; f++) begin
      exp_q.push_back('{ss: 1'b0, mosi: 1'b0, busy: 1'b1, rdy: 1'b0, vld: 1'b0});
      for (int b = 9; b >= 0; b--)
        exp_q.push_back('{ss: 1'b0, mosi: frames[f][b], busy: 1'b1, rdy: 1'b0, vld: 1'b0});
      if (!wr && f == 1) begin
        for (int g = 0; g < RD_GAP; g++)
          exp_q.push_back('{ss: 1'b0, mosi: 1'b0, busy: 1'b1, rdy: 1'b0, vld: 1'b0});
        cap_first = exp_q.size();
        for (int c = 0; c < 8; c++)
          exp_q.push_back('{ss: 1'b0, mosi: 1'b0, busy: 1'b1, rdy: 1'b0, vld: 1'b0});
      end
      exp_q.push_back('{ss: 1'b1, mosi: 1'b0, busy: 1'b1, rdy: 1'b0, vld: (!wr && f == 1)});
    end
    exp_q.push_back('{ss: 1'b1, mosi: 1'b0, busy: 1'b0, rdy: 1'b1, vld: 1'b0});
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, " ss_n"},      bus.SS_n,      1'b1);
    check_val({tag, " mosi"},      bus.MOSI,      1'b0);
    check_val({tag, " rsp_valid"}, bus.rsp_valid, 1'b0);
    check_val({tag, " rsp_rdata"}, bus.rsp_rdata, 8'h00);
    check_val({tag, " busy"},      bus.busy,      1'b0);
    check_val({tag, " req_ready"}, bus.req_ready, 1'b0);
  endtask

  // Entered at the negedge of the accept cycle; returns at the negedge of the
  // trailing idle cycle (which is cycle 0 of a chained follow-up request).
  task automatic run_txn(input bit wr, input logic [7:0] addr, input logic [7:0] wdata,
                         input logic [7:0] rdata, input bit chain, input bit nwr,
                         input logic [7:0] naddr, input logic [7:0] nwdata, input int abort_at);
    build_expect(wr, addr, wdata);
    for (int t = 0; t < exp_q.size() - 1; t++) begin
      if (abort_at > 0 && t == abort_at) begin
        rst = 1'b1;
        bus.req_valid = 1'b0;
        #1;
        exp_rdata = 8'h00;
        check_reset_outputs($sformatf("abort t%0d", t));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_val("ready after release", bus.req_ready, 1'b1);
        check_val("busy after release",  bus.busy,      1'b0);
        for (int k = 0; k < 40; k++) begin
          @(negedge clk);
          bus.MISO = 1'($urandom);
          check_val("no rsp after abort", bus.rsp_valid, 1'b0);
          check_val("ss_n idle after abort", bus.SS_n, 1'b1);
        end
        return;
      end
      if (exp_q[t].vld) exp_rdata = rdata;
      check_val($sformatf("ss_n t%0d", t),      bus.SS_n,      exp_q[t].ss);
      check_val($sformatf("mosi t%0d", t),      bus.MOSI,      exp_q[t].mosi);
      check_val($sformatf("busy t%0d", t),      bus.busy,      exp_q[t].busy);
      check_val($sformatf("req_ready t%0d", t), bus.req_ready, exp_q[t].rdy);
      check_val($sformatf("rsp_valid t%0d", t), bus.rsp_valid, exp_q[t].vld);
      check_val($sformatf("rsp_rdata t%0d", t), bus.rsp_rdata, exp_rdata);
      if (t == 0) begin
        bus.req_valid = 1'b1;
        bus.req_wr    = wr;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
      end else if (t == 1 && chain) begin
        bus.req_wr    = nwr;
        bus.req_addr  = naddr;
        bus.req_wdata = nwdata;
      end else if (!chain && (t == 1 || t == 5 || t == 8)) begin
        bus.req_valid = (t == 5);
        bus.req_wr    = 1'($urandom);
        bus.req_addr  = 8'($urandom);
        bus.req_wdata = 8'($urandom);
      end
      if (cap_first >= 0 && t >= cap_first && t < cap_first + 8)
        bus.MISO = rdata[7 - (t - cap_first)];
      else
        bus.MISO = 1'($urandom);
      @(negedge clk);
    end
  endtask

  logic [7:0] r_addr [21];
  logic [7:0] r_wd   [21];
  logic [7:0] r_rd   [21];
  bit         r_wr   [21];
  bit         r_ch   [21];

  initial begin
    rst           = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_wr    = 1'b0;
    bus.req_addr  = 8'h00;
    bus.req_wdata = 8'h00;
    bus.MISO      = 1'b0;
    exp_rdata     = 8'h00;
    #1;
    check_reset_outputs("async reset");
    @(posedge clk);
    #1;
    check_val("ready held in reset", bus.req_ready, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_val("ready after reset", bus.req_ready, 1'b1);
    @(negedge clk);

    run_txn(1'b1, 8'h3C, 8'hA5, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 0);
    run_txn(1'b0, 8'h3C, 8'h00, 8'hA5, 1'b0, 1'b0, 8'h00, 8'h00, 0);
    run_txn(1'b0, 8'hFF, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 0);
    run_txn(1'b0, 8'h00, 8'h00, 8'hFF, 1'b0, 1'b0, 8'h00, 8'h00, 0);
    run_txn(1'b1, 8'h55, 8'h66, 8'h00, 1'b1, 1'b0, 8'h81, 8'h00, 0);
    run_txn(1'b0, 8'h81, 8'h00, 8'hC3, 1'b0, 1'b0, 8'h00, 8'h00, 0);
    run_txn(1'b0, 8'h42, 8'h00, 8'h99, 1'b0, 1'b0, 8'h00, 8'h00, 18);

    for (int i = 0; i < 21; i++) begin
      r_wr[i]   = 1'($urandom);
      r_addr[i] = 8'($urandom);
      r_wd[i]   = 8'($urandom);
      r_rd[i]   = 8'($urandom);
      r_ch[i]   = (i < 19) && 1'($urandom);
    end
    for (int i = 0; i < 20; i++)
      run_txn(r_wr[i], r_addr[i], r_wd[i], r_rd[i], r_ch[i],
              r_wr[i+1], r_addr[i+1], r_wd[i+1], 0);

    check_val("final ss_n",  bus.SS_n,      1'b1);
    check_val("final busy",  bus.busy,      1'b0);
    check_val("final ready", bus.req_ready, 1'b1);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
